// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch unit's memory-side (MMU) request/response
//                signals, the branch redirect inputs and the decode-side
//                instruction handshake.
//  Modports    : master - the fetch unit itself
//                slave  - the environment (MMU, branch unit, decode stage)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

   // MMU side
   logic        mmu_mem_ready;        // one-cycle pulse: data valid for presented address
   logic [31:0] mmu_data_out;         // fetched instruction word
   logic        mmu_read_enable;      // read request active
   logic [31:0] mmu_address;          // word-aligned fetch address
   logic        mmu_write_enable;     // tied low
   logic        mmu_mem_signed_read;  // tied low
   logic [1:0]  mmu_mem_data_width;   // always word width

   // Branch redirect
   logic        redirect_valid;       // taken branch/jump: flush and refetch
   logic [31:0] redirect_pc;          // new fetch address, bits [1:0] ignored

   // Decode handshake
   logic        id_ready;             // decode consumes the head entry
   logic        if_valid;             // head entry valid
   logic [31:0] if_ir;                // head instruction (NOP when invalid)
   logic [31:0] if_pc;                // head instruction address
   logic [31:0] if_pc_plus4;          // if_pc + 4

   modport master (
      input  mmu_mem_ready,
      input  mmu_data_out,
      output mmu_read_enable,
      output mmu_address,
      output mmu_write_enable,
      output mmu_mem_signed_read,
      output mmu_mem_data_width,
      input  redirect_valid,
      input  redirect_pc,
      input  id_ready,
      output if_valid,
      output if_ir,
      output if_pc,
      output if_pc_plus4
   );

   modport slave (
      output mmu_mem_ready,
      output mmu_data_out,
      input  mmu_read_enable,
      input  mmu_address,
      input  mmu_write_enable,
      input  mmu_mem_signed_read,
      input  mmu_mem_data_width,
      output redirect_valid,
      output redirect_pc,
      output id_ready,
      input  if_valid,
      input  if_ir,
      input  if_pc,
      input  if_pc_plus4
   );

endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues word reads to the MMU, keeps
//                a small prefetch FIFO of {pc, instruction} and presents its
//                head to decode. Redirects flush the FIFO; a read that is
//                still outstanding when a redirect arrives is drained (its
//                address held until the MMU answers, the word discarded).
//  Ports       : clk      - single clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - fetch_unit_if.master (MMU, redirect, decode)
//  Parameters  : QUEUE_DEPTH - FIFO entries, power of two, >= 2
//                RESET_PC    - first fetch address after reset
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int          QUEUE_DEPTH = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input wire logic     clk,
   input wire logic     reset_n,
   fetch_unit_if.master bus
);

   localparam int               PTR_W        = $clog2(QUEUE_DEPTH);
   localparam int               CNT_W        = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_full       = CNT_W'(QUEUE_DEPTH);
   localparam logic [31:0]      c_nop        = 32'h0000_0013;
   localparam logic [1:0]       c_width_word = 2'b10;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,   // request presented at fetch_pc
      S_IDLE  = 2'd1,   // queue full, no request
      S_DRAIN = 2'd2    // waiting out a request made before a redirect
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       stale_pc_q, stale_pc_d;
   logic [31:0]       addr_q, addr_d;
   logic              rd_en_q, rd_en_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]       pc_mem_q [QUEUE_DEPTH];
   logic [31:0]       ir_mem_q [QUEUE_DEPTH];

   logic              push;
   logic              pop;
   logic [31:0]       redirect_tgt;
   logic              unused_redirect_lsbs;

   assign redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

   // Only a live (non-draining) request can deliver a word; a redirect
   // in the same cycle discards it.
   assign push = (state_q == S_FETCH) && bus.mmu_mem_ready && !bus.redirect_valid;
   assign pop  = (count_q != '0) && bus.id_ready && !bus.redirect_valid;

   // ---------------------------------------------------------------------
   // Queue bookkeeping
   // ---------------------------------------------------------------------
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.redirect_valid) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Request FSM next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      stale_pc_d = stale_pc_q;
      case (state_q)
         S_FETCH: begin
            if (bus.redirect_valid) begin
               fetch_pc_d = redirect_tgt;
               // Request still outstanding: keep presenting its address
               // until the MMU answers, then throw the word away.
               if (!bus.mmu_mem_ready) begin
                  stale_pc_d = fetch_pc_q;
                  state_d    = S_DRAIN;
               end
            end else if (bus.mmu_mem_ready) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (count_d == c_full) state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (bus.redirect_valid) begin
               fetch_pc_d = redirect_tgt;
               state_d    = S_FETCH;
            end else if (count_q != c_full) begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (bus.redirect_valid) fetch_pc_d = redirect_tgt;
            // The stale answer ends the drain even if another redirect
            // arrives alongside it; the new target is already in fetch_pc.
            if (bus.mmu_mem_ready) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      rd_en_d = (state_d != S_IDLE);
      addr_d  = (state_d == S_DRAIN) ? stale_pc_d : fetch_pc_d;
   end

   // ---------------------------------------------------------------------
   // State registers (outputs registered alongside the FSM)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_FETCH;
         fetch_pc_q <= RESET_PC;
         stale_pc_q <= 32'h0;
         addr_q     <= RESET_PC;
         rd_en_q    <= 1'b1;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         stale_pc_q <= stale_pc_d;
         addr_q     <= addr_d;
         rd_en_q    <= rd_en_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Entry storage needs no reset: count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q] <= fetch_pc_q;
         ir_mem_q[wr_ptr_q] <= bus.mmu_data_out;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.mmu_read_enable     = rd_en_q;
   assign bus.mmu_address         = addr_q;
   assign bus.mmu_write_enable    = 1'b0;
   assign bus.mmu_mem_signed_read = 1'b0;
   assign bus.mmu_mem_data_width  = c_width_word;

   assign bus.if_valid    = (count_q != '0);
   assign bus.if_ir       = (count_q != '0) ? ir_mem_q[rd_ptr_q] : c_nop;
   assign bus.if_pc       = pc_mem_q[rd_ptr_q];
   assign bus.if_pc_plus4 = pc_mem_q[rd_ptr_q] + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A request-level model
//                (next fetch pc, one outstanding request that may be marked
//                for discard, a queue of {pc, ir}) predicts every output on
//                every cycle; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam int          QUEUE_DEPTH = 2;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] c_nop       = 32'h0000_0013;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   fetch_unit_if bus ();

   fetch_unit #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .RESET_PC    (RESET_PC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: request level
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] m_pc;        // address of the next instruction to fetch
   logic [31:0] m_req_addr;  // address of the request being presented
   bit          m_req_on;    // a request is presented
   bit          m_drop;      // the presented request predates a redirect
   int          m_pre_cnt;
   logic [31:0] m_tgt;
   entry_t      m_e;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_pc       = RESET_PC;
         m_req_addr = RESET_PC;
         m_req_on   = 1'b1;
         m_drop     = 1'b0;
      end else begin
         m_pre_cnt = mq.size();
         m_tgt     = bus.redirect_pc & 32'hFFFF_FFFC;
         if (bus.redirect_valid) begin
            mq.delete();
         end else begin
            if (m_pre_cnt != 0 && bus.id_ready) void'(mq.pop_front());
            if (m_req_on && bus.mmu_mem_ready && !m_drop) begin
               m_e.pc = m_req_addr;
               m_e.ir = bus.mmu_data_out;
               mq.push_back(m_e);
            end
         end
         if (m_req_on) begin
            if (!bus.mmu_mem_ready) begin
               if (bus.redirect_valid) begin
                  m_pc   = m_tgt;
                  m_drop = 1'b1;
               end
            end else begin
               if (bus.redirect_valid) m_pc = m_tgt;
               else if (!m_drop)       m_pc = m_pc + 32'd4;
               m_drop     = 1'b0;
               m_req_on   = (mq.size() < QUEUE_DEPTH);
               m_req_addr = m_pc;
            end
         end else begin
            if (bus.redirect_valid) begin
               m_pc     = m_tgt;
               m_req_on = 1'b1;
            end else if (m_pre_cnt < QUEUE_DEPTH) begin
               m_req_on = 1'b1;
            end
            m_req_addr = m_pc;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle comparison against the model
   // ------------------------------------------------------------------
   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check32("read_enable", {31'h0, bus.mmu_read_enable}, {31'h0, m_req_on});
         check32("address", bus.mmu_address, m_req_on ? m_req_addr : m_pc);
         check32("if_valid", {31'h0, bus.if_valid}, {31'h0, mq.size() != 0});
         if (mq.size() != 0) begin
            check32("if_ir", bus.if_ir, mq[0].ir);
            check32("if_pc", bus.if_pc, mq[0].pc);
            check32("if_pc_plus4", bus.if_pc_plus4, mq[0].pc + 32'd4);
         end else begin
            check32("if_ir_nop", bus.if_ir, c_nop);
         end
         check32("write_enable", {31'h0, bus.mmu_write_enable}, 32'h0);
         check32("signed_read", {31'h0, bus.mmu_mem_signed_read}, 32'h0);
         check32("data_width", {30'h0, bus.mmu_mem_data_width}, 32'h2);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   function automatic logic [31:0] word_at(input logic [31:0] a);
      case (a)
         32'h0:   word_at = 32'h0050_0093;
         32'h4:   word_at = 32'h0010_0113;
         default: word_at = {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
      endcase
   endfunction

   // Answer the presented request (if allowed) with the word at its address.
   task automatic drive_mem(input bit allow);
      bus.mmu_mem_ready = allow && bus.mmu_read_enable;
      bus.mmu_data_out  = word_at(bus.mmu_address);
   endtask

   task automatic reset_checks();
      check32("rst_read_enable", {31'h0, bus.mmu_read_enable}, 32'h1);
      check32("rst_address", bus.mmu_address, RESET_PC);
      check32("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
      check32("rst_if_ir", bus.if_ir, c_nop);
   endtask

   // Returns at negedge+2 with reset released and inputs idle.
   task automatic apply_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      bus.mmu_mem_ready  = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready       = 1'b0;
      #1 reset_checks();
      @(negedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main stimulus
   // ------------------------------------------------------------------
   initial begin
      bit found;
      bus.mmu_mem_ready  = 1'b0;
      bus.mmu_data_out   = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready       = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;

      // Back-to-back fetch with a one-cycle ready MMU
      apply_reset();
      bus.id_ready = 1'b1;
      drive_mem(1'b1);
      @(negedge clk);
      check32("b2b_valid0", {31'h0, bus.if_valid}, 32'h1);
      check32("b2b_ir0", bus.if_ir, 32'h0050_0093);
      check32("b2b_pc0", bus.if_pc, 32'h0);
      check32("b2b_addr1", bus.mmu_address, 32'h4);
      drive_mem(1'b1);
      @(negedge clk);
      check32("b2b_ir1", bus.if_ir, 32'h0010_0113);
      check32("b2b_pc1", bus.if_pc, 32'h4);
      check32("b2b_pc1_plus4", bus.if_pc_plus4, 32'h8);
      for (int i = 0; i < 4; i++) begin
         drive_mem(1'b1);
         @(negedge clk);
         check32("b2b_stream_pc", bus.if_pc, 32'h8 + 32'(4 * i));
      end

      // Decode stalled: queue fills, fetch stops, resumes at 8
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive_mem(1'b1);
         @(negedge clk);
      end
      check32("full_read_enable", {31'h0, bus.mmu_read_enable}, 32'h0);
      check32("full_address", bus.mmu_address, 32'h8);
      check32("full_head_pc", bus.if_pc, 32'h0);
      bus.id_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive_mem(1'b1);
         @(negedge clk);
         if (bus.mmu_read_enable) begin
            found = 1'b1;
            break;
         end
      end
      check32("resume_seen", {31'h0, found}, 32'h1);
      check32("resume_address", bus.mmu_address, 32'h8);
      for (int i = 0; i < 4; i++) begin
         drive_mem(1'b1);
         @(negedge clk);
      end

      // Redirect while a request is outstanding: drain then refetch
      apply_reset();
      bus.id_ready       = 1'b1;
      drive_mem(1'b0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      check32("drain_addr_c1", bus.mmu_address, 32'h0);
      for (int i = 0; i < 2; i++) begin
         drive_mem(1'b0);
         @(negedge clk);
         check32("drain_addr_hold", bus.mmu_address, 32'h0);
         check32("drain_read_enable", {31'h0, bus.mmu_read_enable}, 32'h1);
      end
      drive_mem(1'b1);
      @(negedge clk);
      check32("drain_next_addr", bus.mmu_address, 32'h40);
      check32("drain_dropped", {31'h0, bus.if_valid}, 32'h0);
      drive_mem(1'b1);
      @(negedge clk);
      check32("drain_first_pc", bus.if_pc, 32'h40);
      check32("drain_first_valid", {31'h0, bus.if_valid}, 32'h1);

      // Redirect coinciding with ready and pop; unaligned target
      apply_reset();
      drive_mem(1'b1);
      @(negedge clk);
      bus.id_ready       = 1'b1;
      drive_mem(1'b1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      check32("redir_flush_valid", {31'h0, bus.if_valid}, 32'h0);
      check32("redir_addr", bus.mmu_address, 32'h100);
      drive_mem(1'b1);
      @(negedge clk);
      check32("redir_first_pc", bus.if_pc, 32'h100);

      // PC wrap, then reset during a drain
      apply_reset();
      bus.id_ready       = 1'b1;
      drive_mem(1'b1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      check32("wrap_addr_top", bus.mmu_address, 32'hFFFF_FFFC);
      drive_mem(1'b1);
      @(negedge clk);
      check32("wrap_addr_zero", bus.mmu_address, 32'h0);
      check32("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
      check32("wrap_pc_plus4", bus.if_pc_plus4, 32'h0);
      drive_mem(1'b1);
      @(negedge clk);
      drive_mem(1'b0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      check32("drain_stale_addr", bus.mmu_address, 32'h4);
      bus.mmu_mem_ready = 1'b1;
      bus.mmu_data_out  = 32'hDEAD_BEEF;
      #2 reset_n = 1'b0;
      #1 reset_checks();
      @(negedge clk);
      check32("rst_hold_valid", {31'h0, bus.if_valid}, 32'h0);
      #2 reset_n = 1'b1;
      drive_mem(1'b1);
      @(negedge clk);
      check32("post_rst_pc", bus.if_pc, RESET_PC);
      check32("post_rst_ir", bus.if_ir, 32'h0050_0093);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         bus.id_ready       = ($urandom_range(0, 3) != 0);
         bus.mmu_mem_ready  = bus.mmu_read_enable && ($urandom_range(0, 2) != 0);
         bus.mmu_data_out   = $urandom();
         bus.redirect_valid = ($urandom_range(0, 19) == 0);
         bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom();
         if ($urandom_range(0, 799) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clk);
            #2 reset_n = 1'b1;
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
